// File: rtl/wb_stage_ctl.sv
// ============================================================================
// Module   : wb_stage_ctl
// Brief    : MEM/WB write-back stage. Registers the write-back payload,
//            selects the write-back source, aligns/extends load data, stalls
//            on outstanding loads and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage_ctl #(
    parameter  int XLEN       = 32,
    parameter  int REG_ADDR_W = 5,
    parameter  int CNT_W      = 64,
    localparam int OFS_W      = $clog2(XLEN / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc_4,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write_en,
    input  logic [1:0]            in_mem_to_reg_sel,
    input  logic [2:0]            in_load_funct3,
    input  logic [OFS_W-1:0]      in_addr_lo,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  flush,
    output logic                  reg_write_en_out,
    output logic [REG_ADDR_W-1:0] reg_write_addr_out,
    output logic [XLEN-1:0]       reg_write_data_out,
    output logic [CNT_W-1:0]      instret
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic                    we_q, we_d;
    logic [2:0]              f3_q, f3_d;
    logic [OFS_W-1:0]        ofs_q, ofs_d;
    logic                    wen_q, wen_d;
    logic [REG_ADDR_W-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    w_accept;
    logic [XLEN-1:0]         w_sel_data;
    logic [XLEN-1:0]         w_load_data;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;

    assign in_ready = (state_q == IDLE);
    assign w_accept = in_valid && in_ready && !flush;

    // Byte and halfword lanes picked from the latched load offset.
    assign w_byte = mem_rdata[{ofs_q, 3'b000} +: 8];
    assign w_half = mem_rdata[{ofs_q[OFS_W-1:1], 4'b0000} +: 16];

    generate
        if (XLEN == 64) begin : g_xlen64
            logic [31:0] w_word;
            assign w_word = mem_rdata[{ofs_q[2], 5'b00000} +: 32];

            // Load extraction for RV64: word loads can sign or zero extend.
            always_comb begin
                w_load_data = mem_rdata;
                case (f3_q)
                    3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
                    3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
                    3'b010:  w_load_data = {{(XLEN-32){w_word[31]}}, w_word};
                    3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
                    3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
                    3'b110:  w_load_data = {{(XLEN-32){1'b0}}, w_word};
                    default: w_load_data = mem_rdata;
                endcase
            end
        end else begin : g_xlen32
            // Load extraction for RV32: word-sized codes return the raw word.
            always_comb begin
                w_load_data = mem_rdata;
                case (f3_q)
                    3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
                    3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
                    3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
                    3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
                    default: w_load_data = mem_rdata;
                endcase
            end
        end
    endgenerate

    // Non-load write-back source mux; select 11 yields zero.
    always_comb begin
        case (in_mem_to_reg_sel)
            2'b00:   w_sel_data = in_alu_result;
            2'b10:   w_sel_data = in_pc_4;
            default: w_sel_data = '0;
        endcase
    end

    // Next-state and output logic. Write address/data only move on an
    // actual register write, so they hold across idle and rd=0 retirements.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        we_d    = we_q;
        f3_d    = f3_q;
        ofs_d   = ofs_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (in_mem_to_reg_sel == 2'b01) begin
                        rd_d    = in_rd;
                        we_d    = in_reg_write_en;
                        f3_d    = in_load_funct3;
                        ofs_d   = in_addr_lo;
                        state_d = WAIT_MEM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        wen_d = in_reg_write_en && (in_rd != '0);
                        if (wen_d) begin
                            waddr_d = in_rd;
                            wdata_d = w_sel_data;
                        end
                    end
                end
            end
            WAIT_MEM: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rvalid) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                    wen_d   = we_q && (rd_q != '0);
                    if (wen_d) begin
                        waddr_d = rd_q;
                        wdata_d = w_load_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and payload registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            ofs_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            ofs_q   <= ofs_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign reg_write_en_out   = wen_q;
    assign reg_write_addr_out = waddr_q;
    assign reg_write_data_out = wdata_q;
    assign instret            = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_ctl.sv
// ============================================================================
// Module   : tb_wb_stage_ctl
// Brief    : Self-checking bench for wb_stage_ctl (XLEN=32), with a second
//            instance using a 4-bit retired counter to observe wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_ctl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready4;
    logic [31:0] in_pc_4;
    logic [31:0] in_alu_result;
    logic [4:0]  in_rd;
    logic        in_reg_write_en;
    logic [1:0]  in_mem_to_reg_sel;
    logic [2:0]  in_load_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        wen, wen4;
    logic [4:0]  waddr, waddr4;
    logic [31:0] wdata, wdata4;
    logic [63:0] cnt;
    logic [3:0]  cnt4;

    int n_checks;
    int n_fail;

    wb_stage_ctl #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_4(in_pc_4), .in_alu_result(in_alu_result), .in_rd(in_rd),
        .in_reg_write_en(in_reg_write_en), .in_mem_to_reg_sel(in_mem_to_reg_sel),
        .in_load_funct3(in_load_funct3), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .reg_write_en_out(wen), .reg_write_addr_out(waddr),
        .reg_write_data_out(wdata), .instret(cnt)
    );

    wb_stage_ctl #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc_4(in_pc_4), .in_alu_result(in_alu_result), .in_rd(in_rd),
        .in_reg_write_en(in_reg_write_en), .in_mem_to_reg_sel(in_mem_to_reg_sel),
        .in_load_funct3(in_load_funct3), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .reg_write_en_out(wen4), .reg_write_addr_out(waddr4),
        .reg_write_data_out(wdata4), .instret(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [1:0]  ofs;
        logic        rvalid;
        logic [31:0] rdata;
        logic        fl;
        logic        x_ready;
        logic        x_en;
        logic [4:0]  x_addr;
        logic [31:0] x_data;
        int          x_cnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic v, logic [1:0] s, logic [4:0] r, logic w,
                                logic [31:0] a, logic [31:0] p, logic [2:0] f,
                                logic [1:0] o, logic rv, logic [31:0] rdat,
                                logic fl, logic xr, logic xe, logic [4:0] xa,
                                logic [31:0] xd, int xc);
        vec_t t;
        t.valid = v; t.sel = s; t.rd = r; t.we = w; t.alu = a; t.pc4 = p;
        t.f3 = f; t.ofs = o; t.rvalid = rv; t.rdata = rdat; t.fl = fl;
        t.x_ready = xr; t.x_en = xe; t.x_addr = xa; t.x_data = xd; t.x_cnt = xc;
        return t;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, logic [1:0] s, logic [4:0] r, logic w,
                         logic [31:0] a, logic [31:0] p, logic [2:0] f,
                         logic [1:0] o, logic rv, logic [31:0] rdat, logic fl);
        in_valid = v; in_mem_to_reg_sel = s; in_rd = r; in_reg_write_en = w;
        in_alu_result = a; in_pc_4 = p; in_load_funct3 = f; in_addr_lo = o;
        mem_rvalid = rv; mem_rdata = rdat; flush = fl;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state.
    logic        m_busy;
    logic [4:0]  m_prd;
    logic        m_pwe;
    logic [2:0]  m_pf3;
    logic [1:0]  m_pofs;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    longint unsigned m_cnt;

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] ofs, logic [31:0] raw);
        longint unsigned b, h;
        b = (longint'(raw) >> (ofs * 8)) % 256;
        h = (longint'(raw) >> ((ofs / 2) * 16)) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return raw;
        endcase
    endfunction

    task automatic m_retire(logic w, logic [4:0] r, logic [31:0] d);
        m_cnt++;
        m_en = w && (r != 0);
        if (m_en) begin
            m_addr = r;
            m_data = d;
        end
    endtask

    // Advance the model by one cycle using the currently driven inputs.
    task automatic m_step();
        logic [31:0] src;
        m_en = 1'b0;
        if (!m_busy) begin
            if (in_valid && !flush) begin
                if (in_mem_to_reg_sel == 2'b01) begin
                    m_busy = 1'b1; m_prd = in_rd; m_pwe = in_reg_write_en;
                    m_pf3 = in_load_funct3; m_pofs = in_addr_lo;
                end else begin
                    src = (in_mem_to_reg_sel == 2'b00) ? in_alu_result :
                          (in_mem_to_reg_sel == 2'b10) ? in_pc_4 : 32'h0;
                    m_retire(in_reg_write_en, in_rd, src);
                end
            end
        end else if (flush) begin
            m_busy = 1'b0;
        end else if (mem_rvalid) begin
            m_busy = 1'b0;
            m_retire(m_pwe, m_prd, ref_load(m_pf3, m_pofs, mem_rdata));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        idle_in();
        repeat (2) tick();
        check("reset_ready", in_ready, 1);
        check("reset_en", wen, 0);
        check("reset_addr", waddr, 0);
        check("reset_data", wdata, 0);
        check("reset_cnt", cnt, 0);
        rst = 1'b1;
        tick();

        //            v  sel rd  we alu           pc4     f3 ofs rv rdata         fl  rdy en addr data          cnt
        tbl[0]  = mk(1, 0, 5,  1, 32'h1234,     32'h0,  0, 0, 0, 32'h0,        0,  1, 1, 5, 32'h0000_1234, 1);
        tbl[1]  = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 0, 32'h0,        0,  1, 0, 5, 32'h0000_1234, 1);
        tbl[2]  = mk(1, 1, 7,  1, 32'h0,        32'h0,  0, 2, 0, 32'h0,        0,  1, 0, 5, 32'h0000_1234, 1);
        tbl[3]  = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 0, 32'h0,        0,  0, 0, 5, 32'h0000_1234, 1);
        tbl[4]  = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 0, 32'h0,        0,  0, 0, 5, 32'h0000_1234, 1);
        tbl[5]  = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 1, 32'h0080_0000, 0, 0, 1, 7, 32'hFFFF_FF80, 2);
        tbl[6]  = mk(1, 1, 9,  1, 32'h0,        32'h0,  5, 2, 0, 32'h0,        0,  1, 0, 7, 32'hFFFF_FF80, 2);
        tbl[7]  = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 1, 32'hBEEF_0000, 0, 0, 1, 9, 32'h0000_BEEF, 3);
        tbl[8]  = mk(1, 2, 1,  1, 32'h0,        32'h104, 0, 0, 0, 32'h0,       0,  1, 1, 1, 32'h0000_0104, 4);
        tbl[9]  = mk(1, 0, 0,  1, 32'h55,       32'h0,  0, 0, 0, 32'h0,        0,  1, 0, 1, 32'h0000_0104, 5);
        tbl[10] = mk(1, 1, 3,  1, 32'h0,        32'h0,  2, 0, 0, 32'h0,        0,  1, 0, 1, 32'h0000_0104, 5);
        tbl[11] = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 1, 32'h0000_0104, 5);
        tbl[12] = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 0, 32'h0,        0,  1, 0, 1, 32'h0000_0104, 5);
        tbl[13] = mk(1, 0, 8,  1, 32'h77,       32'h0,  0, 0, 0, 32'h0,        1,  1, 0, 1, 32'h0000_0104, 5);
        tbl[14] = mk(1, 3, 4,  1, 32'h99,       32'h88, 0, 0, 0, 32'h0,        0,  1, 1, 4, 32'h0000_0000, 6);
        tbl[15] = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 1, 32'h1111_1111, 0, 1, 0, 4, 32'h0000_0000, 6);
        tbl[16] = mk(1, 1, 6,  1, 32'h0,        32'h0,  4, 1, 1, 32'h0000_AB00, 0, 1, 0, 4, 32'h0000_0000, 6);
        tbl[17] = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 1, 32'h0000_CD00, 0, 0, 1, 6, 32'h0000_00CD, 7);
        tbl[18] = mk(0, 0, 0,  0, 32'h0,        32'h0,  0, 0, 0, 32'h0,        1,  1, 0, 6, 32'h0000_00CD, 7);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].valid, tbl[i].sel, tbl[i].rd, tbl[i].we, tbl[i].alu,
                  tbl[i].pc4, tbl[i].f3, tbl[i].ofs, tbl[i].rvalid, tbl[i].rdata,
                  tbl[i].fl);
            check($sformatf("tbl%0d_ready", i), in_ready, tbl[i].x_ready);
            tick();
            check($sformatf("tbl%0d_en", i), wen, tbl[i].x_en);
            check($sformatf("tbl%0d_addr", i), waddr, tbl[i].x_addr);
            check($sformatf("tbl%0d_data", i), wdata, tbl[i].x_data);
            check($sformatf("tbl%0d_cnt", i), cnt, 64'(tbl[i].x_cnt));
            check($sformatf("tbl%0d_cnt4", i), cnt4, 64'(tbl[i].x_cnt % 16));
        end

        // Counter wrap on the 4-bit instance.
        rst = 1'b0;
        idle_in();
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 2'b00, 5'd1, 1'b1, 32'(i), 32'h0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        idle_in();
        check("wrap_pre_cnt4", cnt4, 15);
        drive(1'b1, 2'b00, 5'd2, 1'b1, 32'hABCD, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0, 1'b0);
        tick();
        idle_in();
        check("wrap_cnt4", cnt4, 0);
        check("wrap_cnt64", cnt, 16);
        check("wrap_data", wdata, 32'hABCD);

        // Asynchronous reset while a load is outstanding.
        drive(1'b1, 2'b01, 5'd3, 1'b1, 32'h0, 32'h0, 3'd2, 2'd0, 1'b0, 32'h0, 1'b0);
        tick();
        idle_in();
        check("arst_pre_ready", in_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ready", in_ready, 1);
        check("arst_en", wen, 0);
        check("arst_addr", waddr, 0);
        check("arst_data", wdata, 0);
        check("arst_cnt", cnt, 0);
        tick();
        rst = 1'b1;
        drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 3'd0, 2'd0, 1'b1, 32'h1234_5678, 1'b0);
        tick();
        idle_in();
        check("late_rvalid_en", wen, 0);
        check("late_rvalid_cnt", cnt, 0);
        check("late_rvalid_ready", in_ready, 1);

        // Randomized run against the reference model.
        m_busy = 1'b0; m_prd = 0; m_pwe = 0; m_pf3 = 0; m_pofs = 0;
        m_en = 1'b0; m_addr = 0; m_data = 0; m_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  $urandom_range(0, 7) != 0, $urandom, $urandom,
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 4, $urandom,
                  $urandom_range(0, 9) == 0);
            check("rnd_ready", in_ready, !m_busy);
            m_step();
            tick();
            check("rnd_en", wen, m_en);
            check("rnd_addr", waddr, m_addr);
            check("rnd_data", wdata, m_data);
            check("rnd_cnt", cnt, m_cnt);
            check("rnd_cnt4", cnt4, m_cnt % 16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
